// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: detects load-use, branch-operand
// and HI/LO-busy hazards that forwarding cannot cover, and tracks total stall cycles.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ins_d,
    input  logic [31:0] ins_e,
    input  logic [31:0] ins_m,
    output logic        stall_pc,
    output logic        stall_d,
    output logic        flush_e,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    function automatic logic is_load(input logic [31:0] ins);
        return ins[31:26] inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    endfunction

    function automatic logic is_md(input logic [31:0] ins);
        return (ins[31:26] == 6'h00) && (ins[5:0] inside {6'h18, 6'h19, 6'h1A, 6'h1B});
    endfunction

    function automatic logic is_hilo(input logic [31:0] ins);
        return is_md(ins) ||
               ((ins[31:26] == 6'h00) && (ins[5:0] inside {6'h10, 6'h11, 6'h12, 6'h13}));
    endfunction

    function automatic logic is_br(input logic [31:0] ins);
        return (ins[31:26] == 6'h04) || (ins[31:26] == 6'h05) ||
               ((ins[31:26] == 6'h00) && (ins[5:0] == 6'h08));
    endfunction

    // Register written by the instruction; 0 means no destination.
    function automatic logic [4:0] dest_of(input logic [31:0] ins);
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        if (op == 6'h00)
            return (fn inside {6'h08, 6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B}) ? 5'd0 : ins[15:11];
        else if ((op inside {[6'h08:6'h0F]}) || is_load(ins))
            return ins[20:16];
        else if (op == 6'h03)
            return 5'd31;
        else
            return 5'd0;
    endfunction

    function automatic logic reads_rs(input logic [31:0] ins);
        logic [5:0] op;
        op = ins[31:26];
        if (op == 6'h02 || op == 6'h03 || op == 6'h0F) return 1'b0;
        if (op == 6'h00 && (ins[5:0] inside {6'h00, 6'h02, 6'h03, 6'h10, 6'h12})) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic reads_rt(input logic [31:0] ins);
        logic [5:0] op;
        op = ins[31:26];
        if (op == 6'h00) return !(ins[5:0] inside {6'h08, 6'h11, 6'h13});
        return op inside {6'h28, 6'h29, 6'h2B, 6'h04, 6'h05};
    endfunction

    logic [4:0]    rs_d, rt_d, dst_e, dst_m;
    logic          rd_rs, rd_rt;
    logic          match_e, match_m;
    logic          h1, h2, h3, h4, stall;
    logic [CW-1:0] md_cnt_q, md_cnt_d;
    logic [31:0]   stall_cnt_q, stall_cnt_d;

    always_comb begin
        rs_d    = ins_d[25:21];
        rt_d    = ins_d[20:16];
        rd_rs   = reads_rs(ins_d);
        rd_rt   = reads_rt(ins_d);
        dst_e   = dest_of(ins_e);
        dst_m   = dest_of(ins_m);
        // Destination $0 never forms a dependency.
        match_e = (dst_e != 5'd0) && ((rd_rs && rs_d == dst_e) || (rd_rt && rt_d == dst_e));
        match_m = (dst_m != 5'd0) && ((rd_rs && rs_d == dst_m) || (rd_rt && rt_d == dst_m));
        md_busy = is_md(ins_e) || (md_cnt_q != '0);
        h1      = is_load(ins_e) && match_e;
        h2      = is_br(ins_d) && match_e;
        h3      = is_br(ins_d) && is_load(ins_m) && match_m;
        h4      = is_hilo(ins_d) && md_busy;
        stall   = (h1 || h2 || h3 || h4) && !reset;
    end

    assign stall_pc  = stall;
    assign stall_d   = stall;
    assign flush_e   = stall;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        md_cnt_d    = md_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (ins_e[31:26] == 6'h00 && (ins_e[5:0] inside {6'h18, 6'h19}))
            md_cnt_d = CW'(MULT_CYCLES);
        else if (ins_e[31:26] == 6'h00 && (ins_e[5:0] inside {6'h1A, 6'h1B}))
            md_cnt_d = CW'(DIV_CYCLES);
        else if (md_cnt_q != '0)
            md_cnt_d = md_cnt_q - 1'b1;
        if (stall)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule
